// File: rtl/sirv_pkg.sv
// Shared helpers for the sirv buffer family: count/pointer widths and
// the wrap-around pointer increment used for non-power-of-two depths.
package sirv_pkg;

  function automatic int cnt_width(input int dp);
    return $clog2(dp + 1);
  endfunction

  function automatic int ptr_width(input int dp);
    return (dp > 1) ? $clog2(dp) : 1;
  endfunction

  function automatic int wrap_inc(input int p, input int dp);
    return (p >= dp - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/sirv_gnrl_dffs.sv
// Generic flop wrappers, active-high asynchronous reset to zero.
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q_o <= '0;
    else if (lden_i) q_o <= d_i;
  end
endmodule

module gnrl_dffr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_o <= '0;
    else     q_o <= d_i;
  end
endmodule

// File: rtl/sirv_pipebuf_mem.sv
// DP x (DW+1) register array: one write port, one combinational read port.
module sirv_pipebuf_mem
  import sirv_pkg::*;
#(
  parameter int DP = 4,
  parameter int DW = 32,
  parameter int PW = ptr_width(DP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [DW:0]   wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [DW:0]   rdata_o
);
  logic [DP-1:0][DW:0] ent_q;

  for (genvar gi = 0; gi < DP; gi++) begin : g_ent
    gnrl_dfflr #(.DW(DW + 1)) u_ent (
      .clk    (clk),
      .rst    (rst),
      .lden_i (we_i && (waddr_i == PW'(gi))),
      .d_i    (wdata_i),
      .q_o    (ent_q[gi])
    );
  end

  // Explicit mux keeps out-of-range addresses (non-power-of-two DP) benign.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DP; i++)
      if (raddr_i == PW'(i)) rdata_o = ent_q[i];
  end
endmodule

// File: rtl/sirv_pipebuf.sv
// Fully registered egress FIFO: o_vld/o_dat/o_cancel and i_rdy all come
// from flops, so neither the forward nor the ready path is combinational.
module sirv_pipebuf
  import sirv_pkg::*;
#(
  parameter int DP = 4,
  parameter int DW = 32,
  parameter int CW = cnt_width(DP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  input  logic          i_cancel,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic          o_cancel,
  input  logic          flush,
  output logic [CW-1:0] fifo_cnt,
  output logic          fifo_half_full
);
  localparam int PW = ptr_width(DP);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rptr_adv;
  logic          full_q, full_d, vld_q, vld_d;
  logic [DW:0]   head_q, head_d, mem_rdata;
  logic          wr, rd, head_ld, head_byp;

  assign wr = i_vld & ~full_q;
  assign rd = vld_q & o_rdy;

  assign rptr_adv = rd ? PW'(wrap_inc(int'(rptr_q), DP)) : rptr_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({wr, rd})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    wptr_d = wr ? PW'(wrap_inc(int'(wptr_q), DP)) : wptr_q;
    rptr_d = rptr_adv;
    if (flush) begin
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  assign full_d = (cnt_d == CW'(DP));
  assign vld_d  = (cnt_d != '0);

  // The incoming word becomes head directly when nothing else would remain
  // in the array after this cycle's read (empty, or count 1 with a read).
  assign head_byp = wr && ((cnt_q == '0) || (rd && (cnt_q == CW'(1))));
  assign head_ld  = flush | rd | head_byp;

  always_comb begin
    head_d = mem_rdata;
    if (head_byp) head_d = {i_cancel, i_dat};
    if (flush)    head_d = '0;
  end

  sirv_pipebuf_mem #(.DP(DP), .DW(DW), .PW(PW)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr & ~flush),
    .waddr_i (wptr_q),
    .wdata_i ({i_cancel, i_dat}),
    .raddr_i (rptr_adv),
    .rdata_o (mem_rdata)
  );

  gnrl_dffr #(.DW(CW)) u_cnt (
    .clk(clk), .rst(rst), .d_i(cnt_d), .q_o(cnt_q)
  );
  gnrl_dffr #(.DW(PW)) u_wptr (
    .clk(clk), .rst(rst), .d_i(wptr_d), .q_o(wptr_q)
  );
  gnrl_dffr #(.DW(PW)) u_rptr (
    .clk(clk), .rst(rst), .d_i(rptr_d), .q_o(rptr_q)
  );
  gnrl_dffr #(.DW(1)) u_full (
    .clk(clk), .rst(rst), .d_i(full_d), .q_o(full_q)
  );
  gnrl_dffr #(.DW(1)) u_vld (
    .clk(clk), .rst(rst), .d_i(vld_d), .q_o(vld_q)
  );
  gnrl_dfflr #(.DW(DW + 1)) u_head (
    .clk(clk), .rst(rst), .lden_i(head_ld), .d_i(head_d), .q_o(head_q)
  );

  assign i_rdy          = ~full_q;
  assign o_vld          = vld_q;
  assign o_dat          = head_q[DW-1:0];
  assign o_cancel       = head_q[DW];
  assign fifo_cnt       = cnt_q;
  assign fifo_half_full = (int'(cnt_q) >= DP / 2);
endmodule
